mul_seq: RTL and testbench



---
 rtl/mul_seq.sv | 116 +++++++++++
 tb/tb_mul_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// mul_seq: multi-cycle unsigned shift-and-add multiplier that borrows the
// shared execute-stage ALU for its accumulations. It skips the add for zero
// multiplier bits and stops as soon as the remaining multiplier bits are zero.
// It returns the low WIDTH bits of the product and a sticky overflow flag.
module mul_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter logic [2:0]  OP_ADD = 3'b000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             add_en;
  logic [WIDTH-1:0] mplier_shr;
  logic             add_wrap;
  logic             shift_lost;

  // An add is issued only for a set multiplier bit while running. A set bit
  // implies mplier_q != 0, so the early-stop cycle never issues an add.
  assign add_en     = (state_q == StRun) && mplier_q[0];
  assign mplier_shr = mplier_q >> 1;
  assign add_wrap   = add_en && (alu_result < acc_q);
  // The multiplicand bit about to be shifted out still has higher multiplier
  // bits left to weight it, so the true product cannot fit.
  assign shift_lost = mcand_q[WIDTH-1] && (mplier_shr != '0);

  // ALU drive: operands are zeroed whenever no accumulation is wanted.
  always_comb begin
    alu_op = OP_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (add_en) begin
      alu_a = acc_q;
      alu_b = mcand_q;
    end
  end

  // Sequencer: state, datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            acc_q    <= '0;
            mcand_q  <= op_a;
            mplier_q <= op_b;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (mplier_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            if (add_en) begin
              acc_q <= alu_result;
            end
            if (add_wrap || shift_lost) begin
              ovf_q <= 1'b1;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_shr;
          end
        end
        StDone: begin
          // start is deliberately not looked at here.
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign product  = acc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq with a behavioural ALU beside it.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        overflow;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Shared ALU: only the add operation matters here.
  assign alu_result = (alu_op == 3'b000) ? 16'(alu_a + alu_b) : 16'h0000;

  mul_seq #(
    .WIDTH  (16),
    .OP_ADD (3'b000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .overflow   (overflow),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int bitlen(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) n = i + 1;
    end
    return n;
  endfunction

  // Starts one multiply from IDLE (caller sits just after a falling edge) and
  // follows it cycle by cycle through DONE and back to IDLE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_prod,
                        input logic exp_ovf, input bit poke_busy, input bit poke_done,
                        input string name);
    int          n;
    logic [31:0] mask;
    logic [31:0] acc_m;
    logic [31:0] mcand_m;
    logic [15:0] mp;
    n     = bitlen(b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    for (int j = 0; j <= n + 1; j++) begin
      @(negedge clk);
      if (j <= n) begin
        check_eq($sformatf("%s.busy%0d", name, j), 32'(busy), 32'd1);
        check_eq($sformatf("%s.done%0d", name, j), 32'(done), 32'd0);
        if (j == 0) begin
          check_eq($sformatf("%s.prod_clr", name), 32'(product), 32'd0);
          check_eq($sformatf("%s.ovf_clr", name), 32'(overflow), 32'd0);
        end
        mp = b >> j;
        check_eq($sformatf("%s.alu_op%0d", name, j), 32'(alu_op), 32'd0);
        if (j < n && mp[0]) begin
          mask    = (32'd1 << j) - 32'd1;
          acc_m   = (32'(a) * (32'(b) & mask)) & 32'hFFFF;
          mcand_m = (32'(a) << j) & 32'hFFFF;
          check_eq($sformatf("%s.alu_a%0d", name, j), 32'(alu_a), acc_m);
          check_eq($sformatf("%s.alu_b%0d", name, j), 32'(alu_b), mcand_m);
        end else begin
          check_eq($sformatf("%s.alu_a%0d", name, j), 32'(alu_a), 32'd0);
          check_eq($sformatf("%s.alu_b%0d", name, j), 32'(alu_b), 32'd0);
        end
      end else begin
        check_eq($sformatf("%s.done", name), 32'(done), 32'd1);
        check_eq($sformatf("%s.busy_end", name), 32'(busy), 32'd0);
        check_eq($sformatf("%s.product", name), 32'(product), 32'(exp_prod));
        check_eq($sformatf("%s.overflow", name), 32'(overflow), 32'(exp_ovf));
      end
      start = 1'b0;
      if (j == 0) begin
        op_a = ~a;
        op_b = ~b;
      end
      if (poke_busy && j == 1 && n >= 1) begin
        start = 1'b1;
        op_a  = 16'h00FF;
        op_b  = 16'h0003;
      end
      if (poke_done && j == n + 1) start = 1'b1;
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check_eq($sformatf("%s.idle_busy", name), 32'(busy), 32'd0);
    check_eq($sformatf("%s.idle_done", name), 32'(done), 32'd0);
    check_eq($sformatf("%s.hold_prod", name), 32'(product), 32'(exp_prod));
    check_eq($sformatf("%s.hold_ovf", name), 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_a  = 16'h0000;
    op_b  = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.product", 32'(product), 32'd0);
    check_eq("rst.overflow", 32'(overflow), 32'd0);
    check_eq("rst.alu_op", 32'(alu_op), 32'd0);
    check_eq("rst.alu_a", 32'(alu_a), 32'd0);
    check_eq("rst.alu_b", 32'(alu_b), 32'd0);

    run_op(16'd3, 16'd5, 16'd15, 1'b0, 1'b0, 1'b0, "m3x5");
    run_op(16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "zero_b");
    run_op(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, "shift_ovf");
    run_op(16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, "ovf_clear");
    run_op(16'h8001, 16'h0003, 16'h8003, 1'b1, 1'b0, 1'b0, "wrap");
    run_op(16'd3, 16'd5, 16'd15, 1'b0, 1'b1, 1'b1, "ignore_start");
    run_op(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, "max_sq");
    run_op(16'h0001, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, "max_lat");

    // Reset in the middle of a long run.
    start = 1'b1;
    op_a  = 16'h0007;
    op_b  = 16'hFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort.pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort.busy", 32'(busy), 32'd0);
    check_eq("abort.done", 32'(done), 32'd0);
    check_eq("abort.product", 32'(product), 32'd0);
    check_eq("abort.overflow", 32'(overflow), 32'd0);
    check_eq("abort.alu_a", 32'(alu_a), 32'd0);
    check_eq("abort.alu_b", 32'(alu_b), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("abort.quiet%0d", i), 32'({busy, done}), 32'd0);
    end
    run_op(16'h00AB, 16'h0102, 16'hAC56, 1'b0, 1'b0, 1'b0, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
